// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALU encodings, FSM states and field widths.
package decode_pkg;

   localparam int OP_W   = 4;
   localparam int IMM6_W = 6;
   localparam int IMM9_W = 9;

   localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
   localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
   localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
   localparam logic [OP_W-1:0] OP_AND  = 4'h3;
   localparam logic [OP_W-1:0] OP_OR   = 4'h4;
   localparam logic [OP_W-1:0] OP_ADDI = 4'h5;
   localparam logic [OP_W-1:0] OP_LD   = 4'h6;
   localparam logic [OP_W-1:0] OP_ST   = 4'h7;
   localparam logic [OP_W-1:0] OP_LI   = 4'h8;
   localparam logic [OP_W-1:0] OP_HALT = 4'hF;

   localparam logic [2:0] ALU_ADD   = 3'd0;
   localparam logic [2:0] ALU_SUB   = 3'd1;
   localparam logic [2:0] ALU_AND   = 3'd2;
   localparam logic [2:0] ALU_OR    = 3'd3;
   localparam logic [2:0] ALU_PASSB = 3'd4;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HAZ    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

endpackage

// File: rtl/imm_ext.sv
// Immediate extension: sign-extends imm6 for ADDI/LD/ST, zero-extends imm9 for LI.
module imm_ext
   import decode_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic [OP_W-1:0]   op,
   input  logic [IMM9_W-1:0] imm9,
   output logic [DW-1:0]     imm
);

   always_comb begin
      imm = '0;
      case (op)
         OP_ADDI, OP_LD, OP_ST: imm = {{(DW-IMM6_W){imm9[IMM6_W-1]}}, imm9[IMM6_W-1:0]};
         OP_LI:                 imm = {{(DW-IMM9_W){1'b0}}, imm9};
         default:               imm = '0;
      endcase
   end

endmodule

// File: rtl/decode_imm_buf.sv
// Decode-stage pipeline register: decodes one instruction per cycle, builds the
// immediate buffer and ALU operand select, and inserts a bubble on load-use hazards.
module decode_imm_buf
   import decode_pkg::*;
#(
   parameter int DW = 16,
   parameter int RW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] in_instr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          stall,
   input  logic          flush,
   output logic          out_valid,
   output logic          cntrl_m7,
   output logic [DW-1:0] imm_buf,
   output logic [2:0]    alu_op,
   output logic [RW-1:0] rd,
   output logic [RW-1:0] rs1,
   output logic [RW-1:0] rs2,
   output logic          reg_we,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic          halt,
   output logic          illegal
);

   state_t state, state_n;

   logic [OP_W-1:0] f_op;
   logic [RW-1:0]   f_rd, f_rs1, f_rs2;
   logic [DW-1:0]   d_imm;
   logic            d_m7, d_we, d_mrd, d_mwr, d_halt, d_illegal, d_use1, d_use2;
   logic [2:0]      d_alu;
   logic [RW-1:0]   d_rd, d_rs1, d_rs2;
   logic            hazard, accept;

   assign f_op  = in_instr[15:12];
   assign f_rd  = in_instr[9 +: RW];
   assign f_rs1 = in_instr[6 +: RW];
   assign f_rs2 = in_instr[3 +: RW];

   imm_ext #(.DW(DW)) u_imm_ext (
      .op   (f_op),
      .imm9 (in_instr[IMM9_W-1:0]),
      .imm  (d_imm)
   );

   // Control decode; ST reads its store-data register from the rd field position.
   always_comb begin
      d_m7      = 1'b0;
      d_alu     = ALU_ADD;
      d_rd      = '0;
      d_rs1     = '0;
      d_rs2     = '0;
      d_we      = 1'b0;
      d_mrd     = 1'b0;
      d_mwr     = 1'b0;
      d_halt    = 1'b0;
      d_illegal = 1'b0;
      d_use1    = 1'b0;
      d_use2    = 1'b0;
      case (f_op)
         OP_NOP: ;
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            d_alu  = f_op[2:0] - 3'd1;
            d_rd   = f_rd;
            d_rs1  = f_rs1;
            d_rs2  = f_rs2;
            d_we   = 1'b1;
            d_use1 = 1'b1;
            d_use2 = 1'b1;
         end
         OP_ADDI, OP_LD: begin
            d_m7   = 1'b1;
            d_rd   = f_rd;
            d_rs1  = f_rs1;
            d_we   = 1'b1;
            d_mrd  = (f_op == OP_LD);
            d_use1 = 1'b1;
         end
         OP_ST: begin
            d_m7   = 1'b1;
            d_rs1  = f_rs1;
            d_rs2  = f_rd;
            d_mwr  = 1'b1;
            d_use1 = 1'b1;
            d_use2 = 1'b1;
         end
         OP_LI: begin
            d_m7  = 1'b1;
            d_alu = ALU_PASSB;
            d_rd  = f_rd;
            d_we  = 1'b1;
         end
         OP_HALT: d_halt = 1'b1;
         default: d_illegal = 1'b1;
      endcase
   end

   // A registered load only exists in RUN; the bubble held in HAZ never matches.
   always_comb begin
      hazard = 1'b0;
      if (state == ST_RUN && in_valid && out_valid && mem_rd)
         hazard = (d_use1 && (f_rs1 == rd)) || (d_use2 && (d_rs2 == rd));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_RUN;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (stall)
         state_n = state;
      else if (flush)
         state_n = (state == ST_HALTED) ? ST_HALTED : ST_RUN;
      else begin
         case (state)
            ST_RUN:    if (hazard) state_n = ST_HAZ;
                       else if (accept && d_halt) state_n = ST_HALTED;
            ST_HAZ:    state_n = (accept && d_halt) ? ST_HALTED : ST_RUN;
            ST_HALTED: state_n = ST_HALTED;
            default:   state_n = ST_RUN;
         endcase
      end
   end

   always_comb begin
      in_ready = !stall && !flush && (state != ST_HALTED) && !hazard;
      accept   = in_valid && in_ready;
   end

   // Anything not accepted (flush, hazard, halted, idle fetch) becomes a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         cntrl_m7  <= 1'b0;
         imm_buf   <= '0;
         alu_op    <= ALU_ADD;
         rd        <= '0;
         rs1       <= '0;
         rs2       <= '0;
         reg_we    <= 1'b0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         halt      <= 1'b0;
         illegal   <= 1'b0;
      end else if (!stall) begin
         if (accept) begin
            out_valid <= 1'b1;
            cntrl_m7  <= d_m7;
            imm_buf   <= d_imm;
            alu_op    <= d_alu;
            rd        <= d_rd;
            rs1       <= d_rs1;
            rs2       <= d_rs2;
            reg_we    <= d_we;
            mem_rd    <= d_mrd;
            mem_wr    <= d_mwr;
            halt      <= halt | d_halt;
            illegal   <= d_illegal;
         end else begin
            out_valid <= 1'b0;
            cntrl_m7  <= 1'b0;
            imm_buf   <= '0;
            alu_op    <= ALU_ADD;
            rd        <= '0;
            rs1       <= '0;
            rs2       <= '0;
            reg_we    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            illegal   <= 1'b0;
         end
      end
   end

endmodule

// File: doc/decode_imm_buf.md
# decode_imm_buf

Decode-stage pipeline register that produces the immediate buffer and the ALU operand-select control consumed by the ALU operand mux `mux7` (select 1 = immediate, 0 = register/forwarded value from `m3`). It accepts one 16-bit instruction per cycle from fetch, decodes opcode and register fields, and sign- or zero-extends the immediate. It also detects load-use hazards and inserts one bubble, back-pressuring fetch. The registered outputs feed the execute stage directly.

## Interface
Parameters:
- DW, 16, instruction/data width
- RW, 3, register index width

Ports:
- clk  in  1  rising-edge clock (one clock domain)
- rst  in  1  asynchronous, active-high reset
- in_instr  in  16  instruction from fetch
- in_valid  in  1  in_instr valid this cycle
- in_ready  out  1  decode accepts in_instr this cycle
- stall  in  1  execute stage holds; all outputs frozen
- flush  in  1  branch or redirect; discard the registered instruction
- out_valid  out  1  registered instruction valid
- cntrl_m7  out  1  1 = ALU operand B is imm_buf, 0 = m3 value
- imm_buf  out  16  extended immediate
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 PASSB
- rd, rs1, rs2  out  3 each  register indices
- reg_we, mem_rd, mem_wr  out  1 each  write-back, load and store enables
- halt  out  1  HALT has been decoded (sticky)
- illegal  out  1  one-cycle pulse for an undefined opcode

## Operation
- Instruction fields: op = [15:12], rd = [11:9], rs1 = [8:6], rs2 = [5:3], imm6 = [5:0], imm9 = [8:0].
- Opcodes:
  - 0000 NOP
  - 0001 ADD, 0010 SUB, 0011 AND, 0100 OR: cntrl_m7 = 0, reg_we = 1
  - 0101 ADDI: imm6 sign-extended, cntrl_m7 = 1, reg_we = 1
  - 0110 LD: rs1 + sext(imm6), cntrl_m7 = 1, mem_rd = 1, reg_we = 1
  - 0111 ST: sext(imm6), cntrl_m7 = 1, mem_wr = 1, rs2 field = [11:9]
  - 1000 LI: imm9 zero-extended, alu_op = PASSB, cntrl_m7 = 1, reg_we = 1
  - 1111 HALT
  - Any other opcode: decoded as NOP with out_valid = 1, and illegal pulses.
- Outputs that do not apply to the decoded instruction are 0.
- State machine:
  - RUN: normal operation.
  - HAZ: one-cycle bubble, then return to RUN.
  - HALTED: terminal until rst.
- Load-use hazard: the registered instruction is a valid LD, the incoming instruction uses rs1 or rs2, and its source index equals the LD's rd. On detection, go RUN→HAZ: in_ready = 0, register a bubble (out_valid = 0, all enables 0), and hold the incoming instruction.
- Register usage for the hazard check: ADD/SUB/AND/OR use rs1 and rs2; ADDI/LD use rs1; ST uses rs1 and [11:9]; LI, NOP and HALT use none.
- Priority: rst > stall > flush > hazard > normal load.
  - stall: hold every register, in_ready = 0.
  - flush: registers become a bubble, state returns to RUN, and in_instr is not accepted that cycle (in_ready = 0).
- HALT: decode it, set halt, enter HALTED. In HALTED, in_ready = 0 and only bubbles are emitted.

## Timing
- Reset values: out_valid = 0, cntrl_m7 = 0, imm_buf = 0, alu_op = 0, rd/rs1/rs2 = 0, all enables = 0, halt = 0, illegal = 0, state RUN, in_ready = 1.
- Latency: one cycle from in_valid·in_ready at edge N to the decoded outputs at edge N+1.
- in_ready is combinational from state, stall, flush and the hazard compare. There is no combinational path from in_instr to any registered output.
- Load-use timing: the hazard costs exactly one bubble cycle. The held instruction is issued on the following edge.
- If stall is asserted while in HAZ, remain in HAZ until stall deasserts.
- If rst is asserted mid-hazard or in HALTED, the block returns immediately to the reset values.
- illegal is high only for the cycle that out_valid presents the offending instruction.

## Structure
- Shared package `decode_pkg`:
  - opcode localparams
  - alu_op encodings
  - state encoding
  - field-slice widths
- One natural sub-module, `imm_ext`: combinational sign/zero extension selected by opcode.

## Test plan
- ADDI 16'h52BD (r1 = r2 + -3) → next cycle: cntrl_m7 = 1, imm_buf = 16'hFFFD, alu_op = 0, rd = 1, rs1 = 2, reg_we = 1.
- ADD 16'h1650 → cntrl_m7 = 0, rd = 3, rs1 = 1, rs2 = 2, imm_buf = 0.
- LI 16'h88F0 → imm_buf = 16'h00F0, alu_op = 4, cntrl_m7 = 1, rd = 4.
- LD 16'h6284 followed by ADD 16'h1650 → in_ready low for one cycle, then one bubble (out_valid = 0), then ADD issued; total 3 cycles from LD issue.
- flush asserted during HAZ → bubble, state RUN; stall held 3 cycles → outputs unchanged; opcode 1010 → illegal pulses with NOP outputs.
- HALT 16'hF000 → halt = 1, in_ready = 0 thereafter; rst pulse → all reset values restored.
